// File: rtl/vga_bar_animator_pkg.sv
// Shared constants, motion states and colour helpers
// for the bar animator.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int COLOR_W      = 10;
    localparam int POS_W        = 10;
    localparam int COORD_W      = 32;
    localparam int SPEED_W      = 4;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RIGHT  = 2'd1,
        LEFT   = 2'd2
    } motion_t;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    // Each channel is either fully off or fully on.
    function automatic rgb_t mk_rgb(logic r, logic g, logic b);
        rgb_t c;
        c.r = {COLOR_W{r}};
        c.g = {COLOR_W{g}};
        c.b = {COLOR_W{b}};
        return c;
    endfunction

endpackage

// File: rtl/vga_bar_animator_if.sv
// Pixel-stream and control bundle between the VGA
// controller side and the bar animator.
interface vga_bar_animator_if;
    import vga_pkg::*;

    logic [COORD_W-1:0] iX;
    logic [COORD_W-1:0] iY;
    logic               iImValid;
    logic               iRun;
    logic [SPEED_W-1:0] iSpeed;
    logic [COLOR_W-1:0] oRed;
    logic [COLOR_W-1:0] oGreen;
    logic [COLOR_W-1:0] oBlue;
    logic [POS_W-1:0]   oBarPos;
    logic               oFrameTick;

    modport master (
        output iX, iY, iImValid, iRun, iSpeed,
        input  oRed, oGreen, oBlue, oBarPos, oFrameTick
    );

    modport slave (
        input  iX, iY, iImValid, iRun, iSpeed,
        output oRed, oGreen, oBlue, oBarPos, oFrameTick
    );

endinterface

// File: rtl/vga_bar_animator_frame_tick.sv
// One-cycle frame pulse on the rising edge of the
// last-visible-pixel condition.
module vga_frame_tick
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               valid,
    output logic               tick
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

    logic cond;
    logic hist;

    assign cond = valid && (x == X_LAST) && (y == Y_LAST);

    // Pixels last two cycles, so the edge register keeps
    // the pulse to a single cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= 1'b0;
            tick <= 1'b0;
        end else begin
            hist <= cond;
            tick <= cond & ~hist;
        end
    end

endmodule

// File: rtl/vga_bar_animator.sv
// Bouncing red bar over a bordered, two-tone background,
// stepped once per frame.
module vga_bar_animator
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BAR_W    = 32
) (
    input  logic               CLK_50,
    input  logic               RST,
    vga_bar_animator_if.slave  bus
);

    localparam logic [10:0] LIM = 11'(H_ACTIVE - BAR_W);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_HALF = COORD_W'(V_ACTIVE / 2);

    motion_t          state;
    logic             dir;
    logic [POS_W-1:0] pos;
    logic             tick;
    logic [10:0]      spd;
    logic [10:0]      fwd;

    vga_frame_tick #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_tick (
        .clk   (CLK_50),
        .rst   (RST),
        .x     (bus.iX),
        .y     (bus.iY),
        .valid (bus.iImValid),
        .tick  (tick)
    );

    assign spd = {7'd0, bus.iSpeed};
    assign fwd = {1'b0, pos} + spd;

    // Dropping iRun always wins over a same-cycle tick.
    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            state <= PAUSED;
            dir   <= 1'b0;
            pos   <= '0;
        end else begin
            unique case (state)
                PAUSED: begin
                    if (bus.iRun)
                        state <= dir ? LEFT : RIGHT;
                end
                RIGHT: begin
                    if (!bus.iRun) begin
                        state <= PAUSED;
                        dir   <= 1'b0;
                    end else if (tick && spd != '0) begin
                        if (fwd >= LIM) begin
                            pos   <= LIM[POS_W-1:0];
                            state <= LEFT;
                        end else begin
                            pos <= fwd[POS_W-1:0];
                        end
                    end
                end
                LEFT: begin
                    if (!bus.iRun) begin
                        state <= PAUSED;
                        dir   <= 1'b1;
                    end else if (tick && spd != '0) begin
                        if ({1'b0, pos} <= spd) begin
                            pos   <= '0;
                            state <= RIGHT;
                        end else begin
                            pos <= pos - POS_W'(bus.iSpeed);
                        end
                    end
                end
                default: state <= PAUSED;
            endcase
        end
    end

    logic [COORD_W-1:0] bar_lo;
    logic [COORD_W-1:0] bar_hi;
    logic               border;
    logic               in_bar;
    logic               top_half;
    rgb_t               rgb_n;
    rgb_t               rgb_q;

    assign bar_lo   = COORD_W'(pos);
    assign bar_hi   = bar_lo + COORD_W'(BAR_W);
    assign border   = (bus.iX == '0) || (bus.iX == X_LAST) ||
                      (bus.iY == '0) || (bus.iY == Y_LAST);
    assign in_bar   = (bus.iX >= bar_lo) && (bus.iX < bar_hi);
    assign top_half = bus.iY < Y_HALF;

    always_comb begin
        rgb_n = '0;
        if (!bus.iImValid)
            rgb_n = '0;
        else if (border)
            rgb_n = mk_rgb(1'b1, 1'b1, 1'b1);
        else if (in_bar)
            rgb_n = mk_rgb(1'b1, 1'b0, 1'b0);
        else
            rgb_n = mk_rgb(1'b0, top_half, 1'b1);
    end

    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST)
            rgb_q <= '0;
        else
            rgb_q <= rgb_n;
    end

    assign bus.oRed       = rgb_q.r;
    assign bus.oGreen     = rgb_q.g;
    assign bus.oBlue      = rgb_q.b;
    assign bus.oBarPos    = pos;
    assign bus.oFrameTick = tick;

endmodule
